// File: rtl/scm_pkg.sv
// Shared types and constants for the SCM stream reader.
package scm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scm_rd_state_e;

    // Two entries cover one word in flight from the SCM plus one word held under backpressure.
    localparam int SCM_RD_BUF_DEPTH = 2;

endpackage

// File: rtl/scm_rd_fifo2.sv
// 2-entry register FIFO. The head comes from a register and is never bypassed from the input.
module scm_rd_fifo2
    import scm_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            count
);

    logic [SCM_RD_BUF_DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
    logic                                        wr_ptr_q;
    logic                                        rd_ptr_q;
    logic [1:0]                                  cnt_q;

    // Storage, pointers and occupancy. Storage is cleared on reset so the head reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = cnt_q;

    a_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt_q <= 2'd2);
    a_no_ovf:    assert property (@(posedge clk) disable iff (rst) !(push && !pop && cnt_q == 2'd2));
    a_no_udf:    assert property (@(posedge clk) disable iff (rst) !(pop && cnt_q == 2'd0));

endmodule

// File: rtl/scm_stream_reader.sv
// Reads a contiguous, wrap-around range of SCM words and streams them out over valid/ready.
module scm_stream_reader
    import scm_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  ReadEnable,
    output logic [ADDR_WIDTH-1:0] ReadAddr,
    input  logic [DATA_WIDTH-1:0] ReadData,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o
);

    localparam int LW = ADDR_WIDTH + 1;

    scm_rd_state_e         state_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [LW-1:0]         issue_left_q;
    logic [LW-1:0]         beats_left_q;
    logic                  inflight_q;
    logic [1:0]            fifo_cnt;
    logic [2:0]            occ_next;
    logic                  pop;
    logic                  issue;

    // Words that will sit in the buffer or on the SCM port after this edge, not counting a new issue.
    assign pop      = valid_o & ready_i;
    assign occ_next = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue    = (state_q == RUN) && (issue_left_q != '0) && (occ_next < 3'd2);

    assign ReadEnable = issue;
    assign ReadAddr   = rd_addr_q;
    assign valid_o    = (fifo_cnt != 2'd0);
    assign last_o     = valid_o && (beats_left_q == LW'(1));
    assign busy_o     = (state_q == RUN) || (state_q == DRAIN);
    assign done_o     = (state_q == DONE);

    // Control FSM with read issue and beat accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rd_addr_q    <= '0;
            issue_left_q <= '0;
            beats_left_q <= '0;
            inflight_q   <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                rd_addr_q    <= rd_addr_q + ADDR_WIDTH'(1);
                issue_left_q <= issue_left_q - LW'(1);
            end
            if (pop) begin
                beats_left_q <= beats_left_q - LW'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            rd_addr_q    <= base_addr_i;
                            issue_left_q <= len_i;
                            beats_left_q <= len_i;
                            state_q      <= RUN;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (issue && issue_left_q == LW'(1)) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (pop && beats_left_q == LW'(1)) state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    scm_rd_fifo2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .wdata (ReadData),
        .pop   (pop),
        .head  (data_o),
        .count (fifo_cnt)
    );

endmodule

// File: tb/tb_scm_stream_reader.sv
// Bench for scm_stream_reader: SCM model, transfer-level scoreboard, directed scenarios.
module tb_scm_stream_reader;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic [AW:0]   len_i = '0;
    logic          busy_o, done_o, ReadEnable, valid_o, last_o;
    logic [AW-1:0] ReadAddr;
    logic [DW-1:0] ReadData, data_o;
    logic          ready_i = 1'b1;

    always #5 clk = ~clk;

    scm_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .ReadEnable(ReadEnable), .ReadAddr(ReadAddr),
        .ReadData(ReadData), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o)
    );

    // SCM read port: address registered on ReadEnable, data held otherwise.
    logic [DW-1:0] scm_mem [NW];
    logic [DW-1:0] rd_q = '0;
    initial for (int i = 0; i < NW; i++) scm_mem[i] = 32'hA000_0000 + i;
    always @(posedge clk) if (ReadEnable) rd_q <= scm_mem[ReadAddr];
    assign ReadData = rd_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Ready pattern: mode 0 holds ready high, mode 1 repeats 1,0,0,1.
    int rdy_mode = 0;
    int rdy_k = 0;
    int pat[4] = '{1, 0, 0, 1};
    always @(posedge clk) begin
        #1;
        ready_i = (rdy_mode == 0) ? 1'b1 : (pat[rdy_k % 4] != 0);
        rdy_k++;
    end

    // Transfer-level model: expected read addresses and words, outstanding reads, done/busy timing.
    logic [DW-1:0] exp_data[$];
    logic [AW-1:0] exp_addr[$];
    logic [AW-1:0] addr_log[$];
    logic [DW-1:0] beat_data[$];
    int            beat_cyc[$];
    bit            m_idle = 1'b1;
    bit            m_busy = 1'b0;
    int            done_due = -1;
    int            done_seen = -1;
    int            acc_edge = -1;
    int            m_out = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (rst) begin
            exp_data.delete();
            exp_addr.delete();
            m_idle = 1'b1; m_busy = 1'b0; done_due = -1; m_out = 0; prev_stall = 1'b0;
        end else begin
            check("done", done_o, cyc == done_due);
            check("busy", busy_o, m_busy);
            if (done_o) done_seen = cyc;
            if (ReadEnable) begin
                if (exp_addr.size() == 0) check("unexpected_read", 1, 0);
                else check("read_addr", ReadAddr, exp_addr.pop_front());
                addr_log.push_back(ReadAddr);
                m_out++;
            end
            if (valid_o && ready_i) m_out--;
            if (ReadEnable) check("outstanding_le2", m_out <= 2, 1);
            if (prev_stall) check("stall_hold", {valid_o, data_o}, {1'b1, prev_data});
            if (valid_o) begin
                if (exp_data.size() == 0) check("unexpected_valid", 1, 0);
                else begin
                    check("data", data_o, exp_data[0]);
                    check("last", last_o, exp_data.size() == 1);
                end
            end
            if (valid_o && ready_i && exp_data.size() != 0) begin
                void'(exp_data.pop_front());
                beat_cyc.push_back(cyc);
                beat_data.push_back(data_o);
                if (exp_data.size() == 0) begin
                    done_due = cyc + 1;
                    m_busy = 1'b0;
                end
            end
            prev_stall = valid_o && !ready_i;
            prev_data  = data_o;
            if (start_i && m_idle) begin
                m_idle = 1'b0;
                acc_edge = cyc + 1;
                beat_cyc.delete(); beat_data.delete(); addr_log.delete();
                if (len_i == 0) done_due = cyc + 1;
                else begin
                    m_busy = 1'b1;
                    for (int i = 0; i < int'(len_i); i++) begin
                        exp_addr.push_back(AW'(int'(base_addr_i) + i));
                        exp_data.push_back(scm_mem[(int'(base_addr_i) + i) % NW]);
                    end
                end
            end
            if (cyc == done_due) m_idle = 1'b1;
        end
    end

    task automatic do_start(input int b, input int l);
        @(posedge clk); #1;
        start_i = 1'b1; base_addr_i = AW'(b); len_i = (AW+1)'(l);
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (!m_idle) begin
            @(negedge clk); #1;
            k++;
            if (k > budget) begin
                check("wait_idle_timeout", 0, 1);
                return;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NW-1:0] seen;
        int k;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_re", ReadEnable, 0);
        check("rst_last", last_o, 0);
        check("rst_data", data_o, 0);
        check("rst_addr", ReadAddr, 0);
        rst = 1'b0;

        // Basic: base 3, len 4, ready high.
        do_start(3, 4);
        wait_idle(50);
        check("basic_beats", beat_cyc.size(), 4);
        check("basic_first_cyc", beat_cyc[0], acc_edge + 2);
        check("basic_last_cyc", beat_cyc[3], acc_edge + 5);
        check("basic_first_word", beat_data[0], 32'hA000_0003);
        check("basic_last_word", beat_data[3], 32'hA000_0006);
        check("basic_done_cyc", done_seen, acc_edge + 6);

        // Wrap: base 30, len 4.
        do_start(30, 4);
        wait_idle(50);
        check("wrap_n", addr_log.size(), 4);
        check("wrap_a0", addr_log[0], 30);
        check("wrap_a1", addr_log[1], 31);
        check("wrap_a2", addr_log[2], 0);
        check("wrap_a3", addr_log[3], 1);
        check("wrap_d2", beat_data[2], 32'hA000_0000);

        // Backpressure: ready 1,0,0,1 repeating.
        rdy_mode = 1;
        do_start(10, 8);
        wait_idle(200);
        rdy_mode = 0;
        check("bp_beats", beat_data.size(), 8);
        check("bp_d7", beat_data[7], 32'hA000_0011);

        // Zero length.
        do_start(7, 0);
        wait_idle(20);
        check("len0_done_cyc", done_seen, acc_edge);
        check("len0_reads", addr_log.size(), 0);
        check("len0_beats", beat_cyc.size(), 0);

        // Full length from base 17.
        do_start(17, 32);
        wait_idle(100);
        seen = '0;
        foreach (addr_log[i]) seen[addr_log[i]] = 1'b1;
        check("full_reads", addr_log.size(), 32);
        check("full_cover", seen, 32'hFFFF_FFFF);
        check("full_beats", beat_cyc.size(), 32);
        check("full_done_cyc", done_seen, acc_edge + 34);

        // Start while busy is ignored.
        do_start(0, 6);
        @(posedge clk); #1;
        start_i = 1'b1; base_addr_i = AW'(9); len_i = 6'd2;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_idle(50);
        check("busy_start_beats", beat_data.size(), 6);
        check("busy_start_d5", beat_data[5], 32'hA000_0005);

        // Reset at the third beat.
        do_start(5, 8);
        k = 0;
        while (beat_cyc.size() < 2 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("rst_mid_reached", beat_cyc.size(), 2);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_valid", valid_o, 0);
        check("rst_mid_busy", busy_o, 0);
        check("rst_mid_re", ReadEnable, 0);
        check("rst_mid_done", done_o, 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        do_start(0, 2);
        wait_idle(50);
        check("post_rst_beats", beat_data.size(), 2);
        check("post_rst_d1", beat_data[1], 32'hA000_0001);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
